// File: rtl/stream_io_port.sv
// Two-channel buffered stream port on the shared tri-state data bus.
// Optional sticky error flags enabled by defining STREAM_IO_ERR_EN.

module stream_io_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       wr_next;
  logic [AW:0]       rd_next;
  logic              push;
  logic              pop;

  // The extra pointer MSB tells a wrapped (full) writer from an equal (empty) one.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = push_req && !full;
  assign pop   = pop_req && !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    wr_next = wr_ptr;
    rd_next = rd_ptr;
    if (push) wr_next = wr_ptr + 1'b1;
    if (pop)  rd_next = rd_ptr + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      count  <= wr_next - rd_next;
    end
  end

  // NOTE: storage has no reset; pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

module stream_io_port #(
  parameter int DATA_W    = 8,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(IN_DEPTH):0]    in_count,
  output logic [$clog2(OUT_DEPTH):0]   out_count
`ifdef STREAM_IO_ERR_EN
  ,
  input  logic                         err_clr,
  output logic [1:0]                   err_flags
`endif
);
  logic [DATA_W-1:0] in_head;
  logic              in_full;
  logic              in_empty;
  logic              out_full;
  logic              out_empty;

  stream_io_fifo #(.DATA_W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_req (in_valid),
    .pop_req  (cpu_read),
    .wdata    (in_data),
    .head     (in_head),
    .full     (in_full),
    .empty    (in_empty),
    .count    (in_count)
  );

  stream_io_fifo #(.DATA_W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_req (cpu_write),
    .pop_req  (out_ready),
    .wdata    (cpu_wdata),
    .head     (out_data),
    .full     (out_full),
    .empty    (out_empty),
    .count    (out_count)
  );

  // Drive the shared bus only while the decoder selects us for a read.
  assign cpu_rdata = cpu_read ? in_head : 'z;
  assign cpu_stall = (cpu_read && in_empty) || (cpu_write && out_full);
  assign in_ready  = !in_full;
  assign out_valid = !out_empty;

`ifdef STREAM_IO_ERR_EN
  // Sticky flags; a new event in the clearing cycle keeps its flag set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flags <= 2'b00;
    end else begin
      err_flags[0] <= (cpu_read && in_empty)  || (err_flags[0] && !err_clr);
      err_flags[1] <= (cpu_write && out_full) || (err_flags[1] && !err_clr);
    end
  end
`endif
endmodule

// File: tb/tb_stream_io_port.sv
// Self-checking bench for stream_io_port: vector table plus queue scoreboard.
// Define STREAM_IO_ERR_EN on both RTL and bench to also check the error flags.

module tb_stream_io_port;
  localparam int DW  = 8;
  localparam int ID  = 16;
  localparam int OD  = 16;
  localparam int ICW = $clog2(ID) + 1;
  localparam int OCW = $clog2(OD) + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           cpu_read;
  logic           cpu_write;
  logic [DW-1:0]  cpu_wdata;
  wire  [DW-1:0]  cpu_rdata;
  logic           cpu_stall;
  logic [DW-1:0]  in_data;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic [ICW-1:0] in_count;
  logic [OCW-1:0] out_count;
`ifdef STREAM_IO_ERR_EN
  logic           err_clr;
  logic [1:0]     err_flags;
  logic [1:0]     err_m;
`endif

  stream_io_port #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_count  (in_count),
    .out_count (out_count)
`ifdef STREAM_IO_ERR_EN
    ,
    .err_clr   (err_clr),
    .err_flags (err_flags)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] out_q[$];

  typedef struct {
    logic          iv;
    logic [DW-1:0] id;
    logic          rd;
    logic          wr;
    logic [DW-1:0] wd;
    logic          orr;
    int            exp_in_count;
    logic          exp_stall;
    logic [DW-1:0] exp_rdata;
    int            exp_out_count;
    logic          exp_out_valid;
    logic [DW-1:0] exp_out_data;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle's inputs, check outputs against the queue model at the
  // falling edge, then advance the model by what the rising edge commits.
  task automatic drive_check(input logic iv, input logic [DW-1:0] id, input logic rd,
                             input logic wr, input logic [DW-1:0] wd, input logic orr);
    logic in_full_m, in_empty_m, out_full_m, out_empty_m;
    in_valid  = iv;
    in_data   = id;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_wdata = wd;
    out_ready = orr;
    @(negedge clk);
    in_full_m   = (in_q.size() == ID);
    in_empty_m  = (in_q.size() == 0);
    out_full_m  = (out_q.size() == OD);
    out_empty_m = (out_q.size() == 0);
    check("in_ready",  in_ready,  !in_full_m);
    check("out_valid", out_valid, !out_empty_m);
    check("in_count",  in_count,  in_q.size());
    check("out_count", out_count, out_q.size());
    check("cpu_stall", cpu_stall, (rd && in_empty_m) || (wr && out_full_m));
    if (rd && !in_empty_m) check("cpu_rdata", cpu_rdata, in_q[0]);
    if (!out_empty_m)      check("out_data",  out_data,  out_q[0]);
`ifdef STREAM_IO_ERR_EN
    check("err_flags", err_flags, err_m);
    err_m[0] = (rd && in_empty_m) || (err_m[0] && !err_clr);
    err_m[1] = (wr && out_full_m) || (err_m[1] && !err_clr);
`endif
    if (rd && !in_empty_m)  void'(in_q.pop_front());
    if (iv && !in_full_m)   in_q.push_back(id);
    if (orr && !out_empty_m) void'(out_q.pop_front());
    if (wr && !out_full_m)  out_q.push_back(wd);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic rd,
                       input logic wr, input logic [DW-1:0] wd, input logic orr);
    drive_check(iv, id, rd, wr, wd, orr);
    next_edge();
  endtask

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] id, input logic rd,
                              input logic wr, input logic [DW-1:0] wd, input logic orr,
                              input int eic, input logic est, input logic [DW-1:0] erd,
                              input int eoc, input logic eov, input logic [DW-1:0] eod);
    vec_t v;
    v.iv = iv; v.id = id; v.rd = rd; v.wr = wr; v.wd = wd; v.orr = orr;
    v.exp_in_count = eic; v.exp_stall = est; v.exp_rdata = erd;
    v.exp_out_count = eoc; v.exp_out_valid = eov; v.exp_out_data = eod;
    return v;
  endfunction

  initial begin
    //           iv  id     rd  wr  wd     orr  in_cnt stall rdata  out_cnt ov  odata
    vecs[0]  = mk(1, 8'h11, 0, 0, 8'h00, 0,   0,     0,    8'h00, 0,      0,  8'h00);
    vecs[1]  = mk(1, 8'h22, 0, 0, 8'h00, 0,   1,     0,    8'h00, 0,      0,  8'h00);
    vecs[2]  = mk(1, 8'h33, 0, 0, 8'h00, 0,   2,     0,    8'h00, 0,      0,  8'h00);
    vecs[3]  = mk(0, 8'h00, 1, 0, 8'h00, 0,   3,     0,    8'h11, 0,      0,  8'h00);
    vecs[4]  = mk(0, 8'h00, 1, 0, 8'h00, 0,   2,     0,    8'h22, 0,      0,  8'h00);
    vecs[5]  = mk(0, 8'h00, 1, 0, 8'h00, 0,   1,     0,    8'h33, 0,      0,  8'h00);
    vecs[6]  = mk(0, 8'h00, 0, 1, 8'hA5, 0,   0,     0,    8'h00, 0,      0,  8'h00);
    vecs[7]  = mk(0, 8'h00, 0, 0, 8'h00, 0,   0,     0,    8'h00, 1,      1,  8'hA5);
    vecs[8]  = mk(0, 8'h00, 0, 0, 8'h00, 1,   0,     0,    8'h00, 1,      1,  8'hA5);
    vecs[9]  = mk(0, 8'h00, 0, 0, 8'h00, 0,   0,     0,    8'h00, 0,      0,  8'h00);
    vecs[10] = mk(0, 8'h00, 1, 0, 8'h00, 0,   0,     1,    8'h00, 0,      0,  8'h00);
    vecs[11] = mk(0, 8'h00, 0, 0, 8'h00, 0,   0,     0,    8'h00, 0,      0,  8'h00);

    in_valid = 0; in_data = '0; cpu_read = 1; cpu_write = 0; cpu_wdata = '0; out_ready = 0;
`ifdef STREAM_IO_ERR_EN
    err_clr = 0;
    err_m   = 2'b00;
`endif
    reset = 1;
    #12;
    check("reset_stall",     cpu_stall, 1'b1);
    check("reset_in_ready",  in_ready,  1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_in_count",  in_count,  0);
    check("reset_out_count", out_count, 0);
    cpu_read = 0;
    #3 reset = 0;
    next_edge();

    // Basic in-order read, single output word, read on empty.
    for (int i = 0; i < 12; i++) begin
      drive_check(vecs[i].iv, vecs[i].id, vecs[i].rd, vecs[i].wr, vecs[i].wd, vecs[i].orr);
      check($sformatf("vec%0d_in_count", i), in_count, vecs[i].exp_in_count);
      check($sformatf("vec%0d_stall", i), cpu_stall, vecs[i].exp_stall);
      check($sformatf("vec%0d_out_count", i), out_count, vecs[i].exp_out_count);
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_out_valid);
      if (vecs[i].rd && !vecs[i].exp_stall)
        check($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_out_valid)
        check($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_out_data);
      next_edge();
    end
`ifdef STREAM_IO_ERR_EN
    err_clr = 1;
    cycle(0, 8'h00, 0, 0, 8'h00, 0);
    err_clr = 0;
`endif

    // Fill the input FIFO, offer a 17th word, then pop while still offering.
    for (int i = 0; i < ID; i++) cycle(1, 8'h40 + 8'(i), 0, 0, 8'h00, 0);
    drive_check(1, 8'hEE, 0, 0, 8'h00, 0);
    check("full_in_ready", in_ready, 1'b0);
    check("full_in_count", in_count, ID);
    next_edge();
    cycle(1, 8'hEF, 1, 0, 8'h00, 0);
    drive_check(0, 8'h00, 0, 0, 8'h00, 0);
    check("after_pop_in_ready", in_ready, 1'b1);
    next_edge();
    for (int i = 0; i < ID - 1; i++) cycle(0, 8'h00, 1, 0, 8'h00, 0);

    // Fill the output FIFO, then an overflowing write of 0xFF.
    for (int i = 0; i < OD; i++) cycle(0, 8'h00, 0, 1, 8'h80 + 8'(i), 0);
    drive_check(0, 8'h00, 0, 1, 8'hFF, 0);
    check("ovf_stall", cpu_stall, 1'b1);
    next_edge();
    drive_check(0, 8'h00, 0, 0, 8'h00, 0);
    check("ovf_out_count", out_count, OD);
`ifdef STREAM_IO_ERR_EN
    check("ovf_err_flags", err_flags, 2'b10);
`endif
    next_edge();
`ifdef STREAM_IO_ERR_EN
    cycle(0, 8'h00, 0, 0, 8'h00, 0);
    err_clr = 1;
    cycle(0, 8'h00, 0, 0, 8'h00, 0);
    err_clr = 0;
    drive_check(0, 8'h00, 0, 0, 8'h00, 0);
    check("clr_err_flags", err_flags, 2'b00);
    next_edge();
`endif
    for (int i = 0; i < OD; i++) cycle(0, 8'h00, 0, 0, 8'h00, 1);
    drive_check(0, 8'h00, 0, 0, 8'h00, 1);
    check("drained_out_count", out_count, 0);
    next_edge();

    // Wrap-around with simultaneous push and pop at occupancy 8.
    for (int i = 0; i < 8; i++) cycle(1, 8'h01 + 8'(i), 0, 0, 8'h00, 0);
    for (int i = 0; i < 40; i++) cycle(1, 8'(($urandom % 256)), 1, 0, 8'h00, 0);
    drive_check(0, 8'h00, 0, 0, 8'h00, 0);
    check("wrap_in_count", in_count, 8);
    next_edge();
    for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1, 0, 8'h00, 0);

    // Asynchronous reset pulse between edges with data in both FIFOs.
    for (int i = 0; i < 5; i++) cycle(1, 8'hC0 + 8'(i), 0, 1, 8'hD0 + 8'(i), 0);
    in_valid = 0; cpu_write = 0;
    #2 reset = 1;
    #1;
    check("arst_in_count",  in_count,  0);
    check("arst_in_ready",  in_ready,  1'b1);
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_count", out_count, 0);
    #2 reset = 0;
    in_q.delete();
    out_q.delete();
`ifdef STREAM_IO_ERR_EN
    err_m = 2'b00;
`endif
    next_edge();
    cycle(1, 8'h5A, 0, 1, 8'h77, 0);
    cycle(1, 8'h6B, 1, 0, 8'h00, 1);
    cycle(0, 8'h00, 1, 0, 8'h00, 0);
    cycle(0, 8'h00, 0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
